stack_unit: RTL and testbench

Hardware operand stack for the stack-based multi-cycle MIPS datapath. Holds up to DEPTH words and presents registered top-of-stack (tos) and next-on-stack (nos) values. tos feeds the zero detector that drives the conditional-jump decision; tos and nos also feed the ALU operand inputs. Push, pop and replace-top are issued by the multi-cycle controller, at most one operation per clock.

---
 rtl/stack_unit.sv | 90 +++++++++
 tb/tb_stack_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// stack_unit: registered-TOS/NOS operand stack; define STACK_ERR_EN for sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [AW-1:0]    sp, top_idx, third_idx;
  logic             do_rep, do_push, do_pop;
  assign sp        = count_q[AW-1:0];
  assign top_idx   = sp - AW'(1);
  assign third_idx = sp - AW'(3);
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign do_rep    = !clear && push && pop && !empty;
  assign do_push   = !clear && push && (!pop || empty) && !full;
  assign do_pop    = !clear && pop && !push && !empty;
  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    if (clear) begin
      count_d = '0;
      tos_d   = '0;
      nos_d   = '0;
    end else if (do_rep) begin
      tos_d = din;
    end else if (do_push) begin
      count_d = count_q + CW'(1);
      nos_d   = tos_q;
      tos_d   = din;
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
      tos_d   = nos_q;
      nos_d   = count_q >= CW'(3) ? mem[third_idx] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
    end
  end
  // Array is deliberately unreset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && (do_rep || do_push)) mem[do_rep ? top_idx : sp] <= din;
  end
`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= !clear && (ovf_q || (push && !pop && full));
      unf_q <= !clear && (unf_q || (pop && !push && empty));
    end
  end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
  assign tos   = tos_q;
  assign nos   = nos_q;
  assign count = count_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed plus random checks of stack_unit against a queue-based reference model.
module tb_stack_unit;
  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  tos, nos;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;
  int total = 0;
  int bad = 0;
  int q[$];
  bit m_ovf = 0, m_unf = 0;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop), .din(din),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit err_en();
`ifdef STACK_ERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_model(input string tag);
    int n = q.size();
    chk({tag, ".tos"}, tos, n > 0 ? q[n-1] : 0);
    chk({tag, ".nos"}, nos, n > 1 ? q[n-2] : 0);
    chk({tag, ".count"}, count, n);
    chk({tag, ".empty"}, empty, n == 0);
    chk({tag, ".full"}, full, n == D);
    chk({tag, ".ovf"}, overflow, err_en() & m_ovf);
    chk({tag, ".unf"}, underflow, err_en() & m_unf);
  endtask

  task automatic model(input bit c, input bit p, input bit o, input int d);
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p && o && q.size() > 0) q[q.size()-1] = d;
    else if (p) begin
      if (q.size() < D) q.push_back(d);
      else m_ovf = 1;
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1;
    end
  endtask

  task automatic step(input string tag, input bit c, input bit p, input bit o, input logic [W-1:0] d);
    @(negedge clk);
    clear = c; push = p; pop = o; din = d;
    @(posedge clk);
    model(c, p, o, int'(d));
    #1;
    chk_model(tag);
  endtask

  task automatic reset_model();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    logic [W-1:0] seq [4] = '{8'h16, 8'h00, 8'h0C, 8'h3E};
    logic [W-1:0] tos_exp [4] = '{8'h0C, 8'h00, 8'h16, 8'h00};
    logic [W-1:0] nos_exp [4] = '{8'h00, 8'h16, 8'h00, 8'h00};
    #2 rst_n = 1'b0;
    #1;
    chk_model("reset_async");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("push", 0, 1, 0, seq[i]);
      chk("push_tos_const", tos, seq[i]);
    end
    chk("full_nos_const", nos, 8'h0C);
    chk("full_const", full, 1);
    step("push_full", 0, 1, 0, 8'h55);
    chk("ovf_const", overflow, err_en());
    chk("ovf_tos_hold", tos, 8'h3E);
    for (int i = 0; i < 4; i++) begin
      step("pop", 0, 0, 1, '0);
      chk("pop_tos_const", tos, tos_exp[i]);
      chk("pop_nos_const", nos, nos_exp[i]);
    end
    step("pop_empty", 0, 0, 1, '0);
    chk("unf_const", underflow, err_en());
    chk("unf_count", count, 0);
    step("push07", 0, 1, 0, 8'h07);
    step("replace", 0, 1, 1, 8'h2A);
    chk("replace_tos", tos, 8'h2A);
    chk("replace_count", count, 1);
    step("pop1", 0, 0, 1, '0);
    step("rep_empty", 0, 1, 1, 8'h09);
    chk("rep_empty_tos", tos, 8'h09);
    chk("rep_empty_count", count, 1);
    for (int i = 0; i < 3; i++) step("fill", 0, 1, 0, W'(8'hA0 + i));
    step("rep_full", 0, 1, 1, 8'h77);
    chk("rep_full_ovf", overflow, 0);
    step("ovf2", 0, 1, 0, 8'h11);
    step("clear", 1, 0, 0, '0);
    chk("clear_ovf", overflow, 0);
    chk("clear_count", count, 0);
    step("push_pre", 0, 1, 0, 8'h33);
    @(negedge clk);
    push = 1'b1; pop = 1'b0; din = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    chk_model("reset_mid");
    @(posedge clk);
    #1;
    chk_model("reset_held");
    @(negedge clk) begin rst_n = 1'b1; push = 1'b0; end
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), W'($urandom));
    @(negedge clk) begin push = 0; pop = 0; clear = 0; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
